// File: rtl/i2c_globals_pkg.sv
// ----------------------------------------------------------------------------
// i2c_globals_pkg
// Shared I2C constants and types: address/data widths, the default size of the
// responder register file, the R/W bit encoding and the responder FSM states.
// ----------------------------------------------------------------------------
package i2c_globals_pkg;

   localparam int SLAVE_ADDRESS_WIDTH = 7;
   localparam int DATA_WIDTH          = 8;
   localparam int SLAVE_MEMORY_SIZE   = 12;

   // Value of bit 0 of the address byte.
   typedef enum logic {
      WRITE = 1'b0,
      READ  = 1'b1
   } read_write_e;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_slave_state_e;

endpackage : i2c_globals_pkg

// File: rtl/i2c_bus_sync.sv
// ----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the raw SCL/SDA lines into the pclk domain with 2-flop synchronizers
// and decodes SCL edges plus START/STOP conditions from the synchronized
// levels. A bus change is acted upon by downstream registers on the third
// pclk edge after it is first captured.
//
// Ports
//   pclk        system clock
//   areset      asynchronous active-low reset (flops reset to the idle bus, 1)
//   scl_i/sda_i raw bus lines, asynchronous to pclk
//   scl_o/sda_o synchronized levels
//   scl_rise_o  SCL low->high
//   scl_fall_o  SCL high->low
//   start_o     SDA falls while SCL is high
//   stop_o      SDA rises while SCL is high
// ----------------------------------------------------------------------------
module i2c_bus_sync (
   input  logic pclk,
   input  logic areset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, which a shift chain needs.
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   assign scl_o      = scl_q[1];
   assign sda_o      = sda_q[1];
   assign scl_rise_o =  scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] &  scl_q[2];
   // SCL must be high both before and after the SDA change.
   assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] &  sda_q[2];
   assign stop_o     = scl_q[1] & scl_q[2] &  sda_q[1] & ~sda_q[2];

endmodule : i2c_bus_sync

// File: rtl/i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder
// I2C target with a small 8-bit register file. A write transfer carries a
// register index followed by data bytes stored at auto-incrementing (wrapping)
// addresses; a read transfer returns bytes from the current pointer. No clock
// stretching: SCL is only observed.
//
// Ports
//   pclk      system clock
//   areset    asynchronous active-low reset
//   scl_i     raw bus SCL
//   sda_i     raw bus SDA
//   sda_oe    1 pulls SDA low, 0 releases it
//   busy      high from START until STOP
//   wr_pulse  one-cycle strobe per byte committed to memory
//   wr_addr   register index of the last committed byte
//   wr_data   value of the last committed byte
//   nack_seen sticky: an out-of-range register index was NACKed
// ----------------------------------------------------------------------------
module i2c_slave_responder
   import i2c_globals_pkg::*;
#(
   parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS = 7'h68,
   parameter int                             MEM_DEPTH     = SLAVE_MEMORY_SIZE
) (
   input  logic                  pclk,
   input  logic                  areset,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   output logic                  busy,
   output logic                  wr_pulse,
   output logic [DATA_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  nack_seen
);

   localparam int                    PTR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(MEM_DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] IDX_LAST = DATA_WIDTH'(MEM_DEPTH - 1);

   logic sda_s, scl_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_bus_sync (
      .pclk       (pclk),
      .areset     (areset),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .scl_o      (scl_s),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_slave_state_e      state_q;
   read_write_e           rw_q;
   logic [2:0]            bit_cnt_q;
   logic                  byte_done_q;   // 8th bit sampled; act on next SCL fall
   logic [DATA_WIDTH-1:0] shift_q;
   logic [PTR_W-1:0]      ptr_q;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic                  sda_oe_q, busy_q, wr_pulse_q, nack_seen_q;
   logic [DATA_WIDTH-1:0] wr_addr_q, wr_data_q;

   logic [DATA_WIDTH-1:0] shift_d;
   logic [PTR_W-1:0]      ptr_d;
   logic [DATA_WIDTH-1:0] rd_byte;
   logic                  last_bit;

   assign shift_d  = {shift_q[DATA_WIDTH-2:0], sda_s};
   assign ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
   assign rd_byte  = mem_q[ptr_q];
   assign last_bit = (bit_cnt_q == 3'd7);

   // Received bits are taken on SCL rises; every sda_oe change happens on an
   // SCL fall, so the ACK slot is entered on the fall that follows bit 8.
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         state_q     <= IDLE;
         rw_q        <= WRITE;
         bit_cnt_q   <= '0;
         byte_done_q <= 1'b0;
         shift_q     <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         nack_seen_q <= 1'b0;
         // NOTE: the register file has a defined power-on content, so it is
         // cleared here; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_pulse_q <= 1'b0;
         if (start_det) begin
            state_q     <= ADDR;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b1;
            nack_seen_q <= 1'b0;
         end else if (stop_det) begin
            state_q     <= IDLE;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
         end else if (scl_rise) begin
            case (state_q)
               ADDR, REG, WR_DATA: begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     byte_done_q <= 1'b1;
                     if (state_q == WR_DATA) begin
                        mem_q[ptr_q] <= shift_d;
                        wr_pulse_q   <= 1'b1;
                        wr_addr_q    <= DATA_WIDTH'(ptr_q);
                        wr_data_q    <= shift_d;
                        ptr_q        <= ptr_d;
                     end
                  end
               end
               RD_DATA: begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (last_bit) byte_done_q <= 1'b1;
               end
               RD_ACK: begin
                  if (sda_s) state_q <= IGNORE;   // master NACK ends the read
                  else       ptr_q   <= ptr_d;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state_q)
               ADDR: if (byte_done_q) begin
                  byte_done_q <= 1'b0;
                  if (shift_q[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                     rw_q     <= read_write_e'(shift_q[0]);
                     sda_oe_q <= 1'b1;
                     state_q  <= ADDR_ACK;
                  end else begin
                     state_q  <= IGNORE;
                  end
               end
               ADDR_ACK: begin
                  bit_cnt_q <= '0;
                  if (rw_q == READ) begin
                     shift_q  <= rd_byte;
                     sda_oe_q <= ~rd_byte[DATA_WIDTH-1];
                     state_q  <= RD_DATA;
                  end else begin
                     sda_oe_q <= 1'b0;
                     state_q  <= REG;
                  end
               end
               REG: if (byte_done_q) begin
                  byte_done_q <= 1'b0;
                  if (shift_q <= IDX_LAST) begin
                     ptr_q    <= shift_q[PTR_W-1:0];
                     sda_oe_q <= 1'b1;
                     state_q  <= REG_ACK;
                  end else begin
                     nack_seen_q <= 1'b1;
                     state_q     <= IGNORE;
                  end
               end
               REG_ACK, WR_ACK: begin
                  sda_oe_q  <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= WR_DATA;
               end
               WR_DATA: if (byte_done_q) begin
                  byte_done_q <= 1'b0;
                  sda_oe_q    <= 1'b1;
                  state_q     <= WR_ACK;
               end
               RD_DATA: begin
                  if (byte_done_q) begin
                     byte_done_q <= 1'b0;
                     sda_oe_q    <= 1'b0;
                     state_q     <= RD_ACK;
                  end else begin
                     shift_q  <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                     sda_oe_q <= ~shift_q[DATA_WIDTH-2];
                  end
               end
               RD_ACK: begin
                  bit_cnt_q <= '0;
                  shift_q   <= rd_byte;
                  sda_oe_q  <= ~rd_byte[DATA_WIDTH-1];
                  state_q   <= RD_DATA;
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_pulse  = wr_pulse_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign nack_seen = nack_seen_q;

endmodule : i2c_slave_responder

// File: tb/tb_i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_responder
// Bus-master bench: bit-level I2C master tasks, a register-file model with a
// pointer, and a monitor logging committed writes and any SDA pull-down.
// ----------------------------------------------------------------------------
module tb_i2c_slave_responder;

   localparam int Q     = 6;     // pclk cycles per quarter SCL period
   localparam int DEPTH = 12;

   logic       pclk   = 1'b0;
   logic       areset = 1'b0;
   logic       scl_i  = 1'b1;
   logic       m_sda  = 1'b1;
   wire        sda_i;
   logic       sda_oe, busy, wr_pulse, nack_seen;
   logic [7:0] wr_addr, wr_data;

   // Open-drain bus: either side can pull low.
   assign sda_i = m_sda & ~sda_oe;

   always #5 pclk = ~pclk;

   i2c_slave_responder dut (
      .pclk      (pclk),
      .areset    (areset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .nack_seen (nack_seen)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model.
   logic [7:0] model_mem [DEPTH];
   int         model_ptr;
   logic [7:0] tx_data [$];

   // Monitor.
   logic [15:0] wr_log [$];
   int          sda_low_cnt = 0;
   always @(negedge pclk) begin
      if (wr_pulse) wr_log.push_back({wr_addr, wr_data});
      if (sda_oe) sda_low_cnt++;
   end

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge pclk);
   endtask

   // All bit tasks start and end with SCL low (start/stop excepted).
   task automatic bit_out(input logic b);
      wait_q(1); m_sda = b;
      wait_q(1); scl_i = 1'b1;
      wait_q(2); scl_i = 1'b0;
   endtask

   task automatic bit_in(output logic b);
      wait_q(1); m_sda = 1'b1;
      wait_q(1); scl_i = 1'b1;
      wait_q(1); b = sda_i;
      wait_q(1); scl_i = 1'b0;
   endtask

   task automatic i2c_start();
      if (!scl_i) begin
         wait_q(1); m_sda = 1'b1;
         wait_q(1); scl_i = 1'b1;
         wait_q(1);
      end
      m_sda = 1'b0;
      wait_q(2); scl_i = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_q(1); m_sda = 1'b0;
      wait_q(1); scl_i = 1'b1;
      wait_q(1); m_sda = 1'b1;
      wait_q(2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(~ack);
   endtask

   // Write transfer: address 0xD0, index, then every byte of tx_data.
   task automatic do_write(input logic [7:0] idx);
      logic        ack;
      logic [15:0] exp_ev [$];
      int          base;
      base = wr_log.size();
      i2c_start();
      check("start_clears_nack", nack_seen, 0);
      write_byte(8'hD0, ack);
      check("wr_addr_ack", ack, 1);
      write_byte(idx, ack);
      if (idx < DEPTH) begin
         check("wr_idx_ack", ack, 1);
         model_ptr = idx;
         foreach (tx_data[i]) begin
            write_byte(tx_data[i], ack);
            check("wr_data_ack", ack, 1);
            exp_ev.push_back({8'(model_ptr), tx_data[i]});
            model_mem[model_ptr] = tx_data[i];
            model_ptr = (model_ptr + 1) % DEPTH;
         end
      end else begin
         check("bad_idx_nack", ack, 0);
         check("nack_seen_set", nack_seen, 1);
      end
      i2c_stop();
      check("wr_pulse_count", wr_log.size() - base, exp_ev.size());
      foreach (exp_ev[i]) begin
         if (base + i < wr_log.size()) check("wr_event", wr_log[base + i], exp_ev[i]);
      end
      check("busy_after_stop", busy, 0);
   endtask

   // Index write, repeated START, read n bytes (ACK all but the last).
   task automatic do_read(input logic [7:0] idx, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hD0, ack);
      check("rd_waddr_ack", ack, 1);
      write_byte(idx, ack);
      check("rd_idx_ack", ack, 1);
      model_ptr = idx;
      i2c_start();
      write_byte(8'hD1, ack);
      check("rd_raddr_ack", ack, 1);
      for (int k = 0; k < n; k++) begin
         read_byte(d, k != n - 1);
         check("rd_data", d, model_mem[model_ptr]);
         if (k != n - 1) model_ptr = (model_ptr + 1) % DEPTH;
      end
      i2c_stop();
      check("rd_sda_released", sda_oe, 0);
      check("rd_busy_after_stop", busy, 0);
   endtask

   task automatic do_mismatch(input logic [6:0] a, input logic rw);
      logic ack;
      int   low0;
      low0 = sda_low_cnt;
      i2c_start();
      write_byte({a, rw}, ack);
      check("mm_addr_nack", ack, 0);
      write_byte(8'($urandom), ack);
      check("mm_data_nack", ack, 0);
      check("mm_busy", busy, 1);
      i2c_stop();
      check("mm_busy_after_stop", busy, 0);
      check("mm_never_pulled", sda_low_cnt - low0, 0);
   endtask

   initial begin
      logic       ack, b, exp_b;
      logic [6:0] a;
      int         kind, n, low0;

      foreach (model_mem[i]) model_mem[i] = 8'h00;
      model_ptr = 0;

      // Reset values.
      #23;
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_nack_seen", nack_seen, 0);
      @(negedge pclk) areset = 1'b1;
      wait_q(2);

      // Directed write, read-back, wrap.
      tx_data = '{8'hA5, 8'h5A};
      do_write(8'h03);
      do_read(8'h03, 2);
      tx_data = '{8'h11, 8'h22};
      do_write(8'h0B);
      do_read(8'h0B, 2);

      // Address mismatch.
      do_mismatch(7'h50, 1'b0);

      // Out-of-range index, then a fresh START clears the flag.
      tx_data = '{8'h77};
      do_write(8'h0C);
      i2c_start();
      check("nack_cleared_by_start", nack_seen, 0);
      i2c_stop();

      // Reset during the 4th bit of a read byte (reg 3 holds 0xA5, bit 4 = 0).
      i2c_start();
      write_byte(8'hD0, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'hD1, ack);
      check("rst_rd_addr_ack", ack, 1);
      for (int i = 0; i < 3; i++) bit_in(b);
      wait_q(1); m_sda = 1'b1;
      wait_q(1); scl_i = 1'b1;
      wait_q(1);
      exp_b = ~model_mem[3][4];
      check("rst_pre_sda_oe", sda_oe, exp_b);
      @(negedge pclk);
      #2 areset = 1'b0;
      #1;
      check("rst_async_sda_oe", sda_oe, 0);
      check("rst_async_busy", busy, 0);
      repeat (3) @(negedge pclk);
      check("rst_mid_wr_addr", wr_addr, 0);
      check("rst_mid_wr_data", wr_data, 0);
      areset = 1'b1;
      foreach (model_mem[i]) model_mem[i] = 8'h00;
      model_ptr = 0;
      wait_q(1); scl_i = 1'b0;
      i2c_stop();

      // Without a START the bus traffic is ignored.
      low0 = sda_low_cnt;
      write_byte(8'hD0, ack);
      check("idle_no_ack", ack, 0);
      check("idle_busy", busy, 0);
      check("idle_never_pulled", sda_low_cnt - low0, 0);
      i2c_stop();

      // Randomized transfers.
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 3 || kind == 9) begin
            tx_data.delete();
            n = (kind == 9) ? $urandom_range(2, 3) : $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom));
            do_write((kind == 9) ? 8'd11 : 8'($urandom_range(0, DEPTH - 1)));
         end else if (kind <= 6) begin
            do_read(8'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 4));
         end else if (kind == 7) begin
            tx_data = '{8'($urandom)};
            do_write(8'($urandom_range(DEPTH, 255)));
         end else begin
            do
               a = 7'($urandom);
            while (a == 7'h68);
            do_mismatch(a, 1'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule : tb_i2c_slave_responder
